register_file: RTL
==================

// Module: register_file
// PURPOSE
//   Parametrised multi-entry register file for the CPU datapath. Successor to the
//   single-register bank: DEPTH entries of WIDTH bits, one write port, two
//   registered read ports and write-to-read bypass. Adds an optional hardwired-zero
//   R0 and a per-register busy scoreboard for the issue stage.
//   Sits between decode (read addresses, busy checks) and writeback (write port).
// PARAMETERS
//   WIDTH     8                 data width of each register, >= 1
//   DEPTH     8                 number of registers, >= 2
//   AW        $clog2(DEPTH)     address width (derived, do not override)
//   ZERO_REG  1                 1: R0 always reads 0, writes/busy_set to R0 ignored
// PORTS
//   clk        in   1      single clock, all state updates on posedge
//   rst        in   1      synchronous reset, active-high
//   wr_en      in   1      write strobe (writeback)
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data
//   rd_en_a    in   1      read strobe, port A
//   rd_addr_a  in   AW     read address, port A
//   rd_data_a  out  WIDTH  registered read data, port A
//   busy_a     out  1      registered busy flag of rd_addr_a
//   rd_en_b    in   1      read strobe, port B
//   rd_addr_b  in   AW     read address, port B
//   rd_data_b  out  WIDTH  registered read data, port B
//   busy_b     out  1      registered busy flag of rd_addr_b
//   busy_set   in   1      mark busy_addr as having a pending producer (issue)
//   busy_addr  in   AW     register to mark busy
// BEHAVIOUR
//   - Reset: rst high at a posedge -> all registers 0, all busy bits 0,
//     rd_data_a/b = 0, busy_a/b = 0. rst overrides every other input that cycle.
//   - Write: posedge with wr_en=1 -> reg[wr_addr] <= wr_data. Ignored if
//     wr_addr >= DEPTH, or ZERO_REG=1 and wr_addr=0.
//   - Read: 1-cycle latency. rd_en_x=1 at posedge N -> rd_data_x valid after N.
//     rd_en_x=0 -> rd_data_x and busy_x hold their previous values.
//   - Bypass: read and write to the same addr on the same edge -> rd_data_x =
//     wr_data (write-first). R0 with ZERO_REG=1 always returns 0, no bypass.
//     Both ports may read the same address; each bypasses independently.
//   - Out-of-range read address (DEPTH not a power of 2) -> rd_data_x = 0, busy_x = 0.
//   - Scoreboard: busy_set=1 sets busy[busy_addr]. wr_en clears busy[wr_addr].
//     Set and clear on the same addr in the same cycle -> set wins (bit stays 1).
//     busy_set to R0 (ZERO_REG=1) or out-of-range addr ignored.
//   - busy_x on a read = next-state busy bit of rd_addr_x, i.e. includes the
//     same-cycle clear and set.
//   - No arithmetic; all data paths exactly WIDTH bits, no truncation.
// STRUCTURE
//   - Shared package cpu_pkg: RF_WIDTH, RF_DEPTH, RF_AW constants and
//     typedef logic [RF_AW-1:0] reg_addr_t, logic [RF_WIDTH-1:0] word_t.
//   - Sub-module rf_read_port: address decode, range check, zero-reg and bypass
//     mux, output register for data and busy. Instantiated twice (A, B).
//   - Top: storage array, write decode, busy vector with set/clear priority.
// TESTING
//   1. rst=1 one edge after random writes -> all rd_data=0, busy=0 on reads of R0..R7.
//   2. Write R3=8'hA5, next cycle rd_addr_a=3 -> rd_data_a=8'hA5 one edge later.
//   3. Same edge wr R5=8'h3C, rd_addr_a=5, rd_addr_b=5 -> both outputs 8'h3C (bypass).
//   4. ZERO_REG=1: write R0=8'hFF, read R0 -> 8'h00. busy_set on R0 -> busy_a=0.
//   5. busy_set R2 -> busy_a=1 reading R2. Write R2 -> busy 0.
//      Same-edge busy_set R2 and write R2 -> busy stays 1.
//   6. rd_en_a=0 after reading R3=8'hA5, then write R3=8'h11 -> rd_data_a holds 8'hA5.
//      rst mid-sequence -> outputs 0 next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types for the register file and its users.
package cpu_pkg;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]    reg_addr_t;
  typedef logic [RF_WIDTH-1:0] word_t;

  // True when addr names a real, writable register (exists and is not a hardwired R0).
  function automatic logic rf_addr_ok(input int addr, input int depth, input logic zero_reg);
    return (addr < depth) && !((zero_reg == 1'b1) && (addr == 32'sd0));
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface register_file_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             busy_a;
  logic             rd_en_b;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             busy_b;
  logic             busy_set;
  logic [AW-1:0]    busy_addr;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output busy_set, busy_addr,
    input  rd_data_a, busy_a, rd_data_b, busy_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  busy_set, busy_addr,
    output rd_data_a, busy_a, rd_data_b, busy_b
  );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: range check, hardwired-zero R0, write-first bypass
// and the busy flag taken from the scoreboard's next state.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr_valid,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy_next,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        busy
);

  logic             rd_ok_s;
  logic             hit_s;
  logic [WIDTH-1:0] data_s;
  logic             busy_s;
  logic [WIDTH-1:0] rd_data_r;
  logic             busy_r;

  // Next output value; wr_valid already excludes R0, so R0 never bypasses.
  always_comb begin
    rd_ok_s = rf_addr_ok(32'(rd_addr), DEPTH, ZERO_REG != 32'sd0);
    hit_s   = wr_valid && (wr_addr == rd_addr);
    data_s  = rd_data_r;
    busy_s  = busy_r;
    if (!rd_en) begin
      data_s = rd_data_r;
      busy_s = busy_r;
    end else if (!rd_ok_s) begin
      data_s = {WIDTH{1'b0}};
      busy_s = 1'b0;
    end else if (hit_s) begin
      data_s = wr_data;
      busy_s = busy_next[rd_addr];
    end else begin
      data_s = regs[rd_addr];
      busy_s = busy_next[rd_addr];
    end
  end

  // Output register for data and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      rd_data_r <= data_s;
      busy_r    <= busy_s;
    end
  end

  assign rd_data = rd_data_r;
  assign busy    = busy_r;

endmodule

// File: rtl/register_file.sv
// Multi-entry register file: storage, write decode, busy scoreboard and two
// registered read ports with write-first bypass.
module register_file
  import cpu_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst,
  register_file_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs_r;
  logic [DEPTH-1:0]            busy_r;
  logic [DEPTH-1:0]            busy_next_s;
  logic                        wr_valid_s;
  logic                        set_valid_s;

  // Qualified write/set strobes and scoreboard next state (set beats clear).
  always_comb begin
    wr_valid_s  = bus.wr_en && rf_addr_ok(32'(bus.wr_addr), DEPTH, ZERO_REG != 32'sd0);
    set_valid_s = bus.busy_set && rf_addr_ok(32'(bus.busy_addr), DEPTH, ZERO_REG != 32'sd0);
    busy_next_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      busy_next_s[i] = (set_valid_s && (bus.busy_addr == AW'(i))) ||
                       (busy_r[i] && !(wr_valid_s && (bus.wr_addr == AW'(i))));
    end
  end

  // Storage array and busy vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r <= '0;
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
      if (wr_valid_s) begin
        regs_r[bus.wr_addr] <= bus.wr_data;
      end else begin
        regs_r <= regs_r;
      end
    end
  end

  rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (bus.rd_en_a),
    .rd_addr   (bus.rd_addr_a),
    .wr_valid  (wr_valid_s),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .regs      (regs_r),
    .busy_next (busy_next_s),
    .rd_data   (bus.rd_data_a),
    .busy      (bus.busy_a)
  );

  rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (bus.rd_en_b),
    .rd_addr   (bus.rd_addr_b),
    .wr_valid  (wr_valid_s),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .regs      (regs_r),
    .busy_next (busy_next_s),
    .rd_data   (bus.rd_data_b),
    .busy      (bus.busy_b)
  );

endmodule
